// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them one at a time to a 1-cycle registered ALU
// and returns each captured result over a valid/ready port with a saturating overflow count.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_c,
  output logic             rsp_ovf,
  output logic [1:0]       rsp_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_c,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  state_t state;
  logic [9:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full, push, pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = reset_n && !full;
  assign push = cmd_valid && cmd_ready;
  // a pop always coincides with loading the head onto the ALU
  assign pop = !empty && (state == IDLE || (state == RESP && rsp_ready));
  assign busy = (state != IDLE) || !empty;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      {alu_a, alu_b, alu_op} <= '0;
      {rsp_valid, rsp_c, rsp_ovf, rsp_op} <= '0;
      ovf_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        {alu_a, alu_b, alu_op} <= mem[rp[AW-1:0]];
      end
      case (state)
        IDLE: if (!empty) state <= EXEC;
        EXEC: state <= CAPT;
        CAPT: begin
          {rsp_c, rsp_ovf, rsp_op} <= {alu_c, alu_ovf, alu_op};
          rsp_valid <= 1'b1;
          if (alu_ovf && !(&ovf_count)) ovf_count <= ovf_count + 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= empty ? IDLE : EXEC;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer with a behavioural 4-bit signed ALU
// registered on the same clock and reset.
module tb_alu_cmd_issuer;
  logic clk = 0, reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_ovf, alu_ovf, busy;
  logic [3:0] cmd_a, cmd_b, rsp_c, alu_a, alu_b, alu_c;
  logic [1:0] cmd_op, rsp_op, alu_op;
  logic [7:0] ovf_count;
  int n_chk = 0, n_fail = 0;

  alu_cmd_issuer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_ovf(rsp_ovf), .rsp_op(rsp_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .busy(busy), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    logic [3:0] s;
    logic v;
    s = (op == 2'b11) ? a - b : a + b;
    v = (op == 2'b11) ? (a[3] != b[3]) && (s[3] != a[3]) : (a[3] == b[3]) && (s[3] != a[3]);
    return op == 2'b00 ? {a | b, 1'b0} : op == 2'b01 ? {a & b, 1'b0} : {s, v};
  endfunction

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {alu_c, alu_ovf} <= '0;
    else {alu_c, alu_ovf} <= alu_f(alu_a, alu_b, alu_op);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    logic acc;
    acc = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = cmd_ready;
      tick;
    end
    cmd_valid = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_valid(string tag);
    for (int k = 0; k < 50 && !rsp_valid; k++) tick;
    chk(tag, rsp_valid, 1);
  endtask

  task automatic wait_rsp(logic [3:0] c, logic v, logic [1:0] op);
    rsp_ready = 1;
    wait_valid("rsp_timeout");
    chk("rsp_c", rsp_c, c);
    chk("rsp_ovf", rsp_ovf, v);
    chk("rsp_op", rsp_op, op);
    tick;
    rsp_ready = 0;
  endtask

  initial begin
    reset_n = 0; cmd_valid = 0; rsp_ready = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0;
    tick; tick;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("rst_rsp", {rsp_c, rsp_ovf, rsp_op}, 0);
    chk("rst_ovf_count", ovf_count, 0);
    reset_n = 1;
    tick;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // ADD 3+2 with latency check
    push(4'd3, 4'd2, 2'b10);
    chk("busy_after_push", busy, 1);
    tick; tick;
    chk("lat_not_yet", rsp_valid, 0);
    tick;
    chk("lat_3", rsp_valid, 1);
    chk("add_c", rsp_c, 5);
    chk("add_ovf", rsp_ovf, 0);
    chk("add_op", rsp_op, 2);
    chk("alu_a_issued", alu_a, 3);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_busy", busy, 0);

    // overflow cases
    push(4'd7, 4'd1, 2'b10);
    wait_rsp(4'b1000, 1, 2'b10);
    chk("ovf_count_1", ovf_count, 1);
    push(4'b1000, 4'd1, 2'b11);
    wait_rsp(4'd7, 1, 2'b11);
    chk("ovf_count_2", ovf_count, 2);

    // logic ops in order
    push(4'b0101, 4'b0011, 2'b00);
    push(4'b0101, 4'b0011, 2'b01);
    wait_rsp(4'b0111, 0, 2'b00);
    wait_rsp(4'b0001, 0, 2'b01);

    // fill: 4 queued + 1 in flight, 6th held
    push(4'd1, 4'd2, 2'b10);
    push(4'd2, 4'd5, 2'b11);
    push(4'd8, 4'd1, 2'b00);
    push(4'hF, 4'd6, 2'b01);
    push(4'hC, 4'hB, 2'b10);
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_a = 4'd3; cmd_b = 4'hE; cmd_op = 2'b11; cmd_valid = 1;
    tick; tick; tick;
    chk("held_cmd_ready", cmd_ready, 0);
    chk("held_busy", busy, 1);
    wait_rsp(4'd3, 0, 2'b10);
    chk("freed_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    wait_rsp(4'hD, 0, 2'b11);
    wait_rsp(4'd9, 0, 2'b00);
    wait_rsp(4'd6, 0, 2'b01);
    wait_rsp(4'd7, 1, 2'b10);
    wait_rsp(4'd5, 0, 2'b11);
    chk("ovf_count_3", ovf_count, 3);
    chk("drained_busy", busy, 0);

    // backpressure hold
    push(4'd2, 4'd3, 2'b10);
    push(4'd4, 4'd1, 2'b00);
    wait_valid("hold_timeout");
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rsp", {rsp_c, rsp_ovf, rsp_op}, {4'd5, 1'b0, 2'b10});
      chk("hold_alu", {alu_a, alu_b, alu_op}, {4'd2, 4'd3, 2'b10});
      tick;
    end
    wait_rsp(4'd5, 0, 2'b10);
    wait_rsp(4'd5, 0, 2'b00);

    // reset while EXEC with 3 queued
    push(4'd1, 4'd1, 2'b10);
    wait_valid("pre_rst_timeout");
    push(4'd6, 4'd5, 2'b00);
    push(4'd1, 4'd2, 2'b10);
    push(4'd3, 4'd3, 2'b01);
    push(4'd2, 4'd2, 2'b11);
    chk("pre_rst_full", cmd_ready, 0);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk("pre_rst_alu_a", alu_a, 6);
    reset_n = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("mid_rst_rsp", {rsp_c, rsp_ovf, rsp_op}, 0);
    chk("mid_rst_ovf_count", ovf_count, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    tick;
    reset_n = 1;
    tick; tick; tick; tick;
    chk("after_rst_valid", rsp_valid, 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_cmd_ready", cmd_ready, 1);
    push(4'd1, 4'd1, 2'b10);
    wait_rsp(4'd2, 0, 2'b10);

    // saturation
    for (int i = 0; i < 255; i++) begin
      push(4'd7, 4'd1, 2'b10);
      wait_rsp(4'b1000, 1, 2'b10);
    end
    chk("sat_255", ovf_count, 255);
    push(4'd7, 4'd1, 2'b10);
    wait_rsp(4'b1000, 1, 2'b10);
    chk("sat_hold", ovf_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
